// File: rtl/lr35902_lcd_pkg.sv
// Shared PPU/LCD constants.
// Holds the capture state encoding, the default visible frame size and the
// framebuffer write entry layout used by the LCD capture block and its FIFO.
package lr35902_lcd_pkg;

  typedef enum logic [1:0] {
    ST_OFF        = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2
  } lcd_state_t;

  localparam int LCD_WIDTH  = 160;
  localparam int LCD_HEIGHT = 144;

  localparam int ADR_W  = 13;
  localparam int DATA_W = 8;

  // One framebuffer write: byte address plus four packed 2-bit pixels.
  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } fb_entry_t;

endpackage

// File: rtl/lr35902_lcd_fifo.sv
// Two-entry FIFO for pending framebuffer writes.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   clr              synchronous flush (drops all entries)
//   push, push_data  enqueue request and entry; accepted when not full, or
//                    when full and the head pops in the same clk
//   pop              dequeue the head (ignored when empty)
//   head             current head entry, stable until popped
//   full, empty      occupancy flags
module lr35902_lcd_fifo
  import lr35902_lcd_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      clr,
  input  logic      push,
  input  fb_entry_t push_data,
  input  logic      pop,
  output fb_entry_t head,
  output logic      full,
  output logic      empty
);

  fb_entry_t  mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same clk;
  // the write lands in the slot being vacated.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: storage is only two entries, so it is reset to keep the head
      // (and therefore fb_adr/fb_dout) at zero while reset is held.
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clr) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lr35902_lcd.sv
// LCD pixel capture: packs the PPU 2-bit pixel stream four pixels per byte
// and writes the bytes to a framebuffer through a 2-entry FIFO.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   disp_on                 display enable; low forces OFF and flushes writes
//   hsync, vsync            line / frame start strobes (vsync implies hsync)
//   px_out, px              pixel valid and 2-bit shade
//   fb_adr, fb_dout         framebuffer byte address and packed byte
//   fb_write, fb_ack        write request / accept handshake
//   frame_done              pulse when the last byte of a frame is accepted
//   line_err, overrun       sticky protocol error / dropped byte flags
//   err_clr                 clears both sticky flags (a new set wins)
module lr35902_lcd
  import lr35902_lcd_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        disp_on,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        px_out,
  input  logic [1:0]  px,
  output logic [12:0] fb_adr,
  output logic [7:0]  fb_dout,
  output logic        fb_write,
  input  logic        fb_ack,
  output logic        frame_done,
  output logic        line_err,
  output logic        overrun,
  input  logic        err_clr
);

  localparam int              XW             = $clog2(WIDTH + 1);
  localparam int              BYTES_PER_LINE = WIDTH / 4;
  localparam logic [ADR_W-1:0] LAST_ADR      = ADR_W'(HEIGHT * BYTES_PER_LINE - 1);

  lcd_state_t    state;
  lcd_state_t    next_state;
  logic          capture;
  logic          flush;

  logic [XW-1:0] x;
  logic [XW-1:0] line_x;
  logic [XW-1:0] x_next;
  logic [7:0]    y;
  logic [7:0]    line_y;
  logic [5:0]    pack;

  logic          hsync_bad;
  logic          px_ok;
  logic          px_bad;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  fb_entry_t     push_data;
  fb_entry_t     head;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_OFF;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (no latch).
    next_state = state;
    if (!disp_on) begin
      next_state = ST_OFF;
    end else begin
      case (state)
        ST_OFF:        next_state = ST_WAIT_FRAME;
        ST_WAIT_FRAME: if (vsync) next_state = ST_CAPTURE;
        ST_CAPTURE:    next_state = ST_CAPTURE;
        default:       next_state = ST_OFF;
      endcase
    end
  end

  // State-derived controls. The FIFO is flushed in any clk that leads to OFF.
  always_comb begin
    capture = (state == ST_CAPTURE) && disp_on;
    flush   = !disp_on;
  end

  // Position tracking and pixel acceptance. hsync/vsync are applied before
  // the pixel of the same clk, so that pixel becomes x=0 of the new line.
  always_comb begin
    line_x    = hsync ? '0 : x;
    line_y    = vsync ? 8'd0 : ((hsync && (y != 8'd255)) ? y + 8'd1 : y);
    hsync_bad = capture && hsync && (x != '0) && (x != XW'(WIDTH)) && (32'(y) < HEIGHT);
    px_ok     = capture && px_out && (32'(line_x) < WIDTH) && (32'(line_y) < HEIGHT);
    px_bad    = capture && px_out && !px_ok;
    push      = px_ok && (line_x[1:0] == 2'b11);
    x_next    = px_ok ? line_x + XW'(1) : line_x;
    // On the 4th pixel x>>2 still names the group of the first pixel.
    push_data.adr  = ADR_W'(32'(line_y) * BYTES_PER_LINE + 32'(line_x >> 2));
    push_data.data = {pack, px};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x    <= '0;
      y    <= 8'd0;
      pack <= 6'd0;
    end else if (capture) begin
      x <= x_next;
      y <= line_y;
      if (px_ok) begin
        pack <= {pack[3:0], px};
      end
    end else begin
      // OFF and WAIT_FRAME hold the origin so capture starts at y=0, x=0.
      x    <= '0;
      y    <= 8'd0;
      pack <= 6'd0;
    end
  end

  // Sticky flags: a new set in the same clk beats err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (hsync_bad || px_bad) begin
        line_err <= 1'b1;
      end else if (err_clr) begin
        line_err <= 1'b0;
      end
      if (push && full && !pop) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign pop = fb_ack && !empty;

  lr35902_lcd_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign fb_write   = !empty;
  assign fb_adr     = head.adr;
  assign fb_dout    = head.data;
  assign frame_done = pop && (head.adr == LAST_ADR);

endmodule

// File: tb/tb_lr35902_lcd.sv
// Self-checking bench for lr35902_lcd at default geometry (160x144).
module tb_lr35902_lcd;

  localparam int W      = 160;
  localparam int H      = 144;
  localparam int BPL    = W / 4;
  localparam int NBYTES = H * BPL;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_on;
  logic        hsync;
  logic        vsync;
  logic        px_out;
  logic [1:0]  px;
  logic [12:0] fb_adr;
  logic [7:0]  fb_dout;
  logic        fb_write;
  logic        fb_ack;
  logic        frame_done;
  logic        line_err;
  logic        overrun;
  logic        err_clr;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [20:0] wr_q[$];
  int          fd_cnt    = 0;
  logic [12:0] fd_adr    = '0;

  typedef struct {
    logic [1:0]  p0;
    logic [1:0]  p1;
    logic [1:0]  p2;
    logic [1:0]  p3;
    logic [12:0] adr;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  lr35902_lcd dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .disp_on    (disp_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .px_out     (px_out),
    .px         (px),
    .fb_adr     (fb_adr),
    .fb_dout    (fb_dout),
    .fb_write   (fb_write),
    .fb_ack     (fb_ack),
    .frame_done (frame_done),
    .line_err   (line_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  // Record every accepted write and every frame_done pulse.
  always @(negedge clk) begin
    if (fb_write && fb_ack) wr_q.push_back({fb_adr, fb_dout});
    if (frame_done) begin
      fd_cnt++;
      fd_adr = fb_adr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [1:0] v);
    px_out = 1'b1;
    px     = v;
    tick();
    px_out = 1'b0;
  endtask

  task automatic line_start();
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
  endtask

  task automatic start_frame();
    disp_on = 1'b1;
    tick();
    hsync = 1'b1;
    vsync = 1'b1;
    tick();
    hsync = 1'b0;
    vsync = 1'b0;
  endtask

  task automatic fresh();
    disp_on = 1'b0;
    fb_ack  = 1'b0;
    hsync   = 1'b0;
    vsync   = 1'b0;
    px_out  = 1'b0;
    err_clr = 1'b1;
    tick();
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    logic        stable;
    int          adr_bad;
    int          dat_bad;
    int          yy;
    int          xx;
    logic [7:0]  e;

    vecs[0] = '{2'd3, 2'd0, 2'd1, 2'd2, 13'd0, 8'hC6};
    vecs[1] = '{2'd0, 2'd0, 2'd0, 2'd0, 13'd1, 8'h00};
    vecs[2] = '{2'd3, 2'd3, 2'd3, 2'd3, 13'd2, 8'hFF};
    vecs[3] = '{2'd1, 2'd2, 2'd3, 2'd0, 13'd3, 8'h6C};
    vecs[4] = '{2'd2, 2'd1, 2'd0, 2'd3, 13'd4, 8'h93};

    reset_n = 1'b0;
    disp_on = 1'b0;
    hsync   = 1'b0;
    vsync   = 1'b0;
    px_out  = 1'b0;
    px      = 2'd0;
    fb_ack  = 1'b0;
    err_clr = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_fb_write", 32'(fb_write), 0);
    check("rst_fb_adr", 32'(fb_adr), 0);
    check("rst_fb_dout", 32'(fb_dout), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_line_err", 32'(line_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset_n = 1'b1;

    // Packing table on line 0, ack high; each byte appears one clk after
    // its 4th pixel.
    fresh();
    start_frame();
    fb_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_px(vecs[i].p0);
      send_px(vecs[i].p1);
      send_px(vecs[i].p2);
      send_px(vecs[i].p3);
      check($sformatf("vec%0d_fb_write", i), 32'(fb_write), 1);
      check($sformatf("vec%0d_fb_adr", i), 32'(fb_adr), 32'(vecs[i].adr));
      check($sformatf("vec%0d_fb_dout", i), 32'(fb_dout), 32'(vecs[i].dout));
    end

    // Stall: ack low for 12 clks, third byte is dropped.
    fresh();
    start_frame();
    fb_ack = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_px(2'(i % 4));
      if (i >= 3 && !(fb_write === 1'b1 && fb_adr === 13'd0)) stable = 1'b0;
    end
    check("stall_held_adr0", 32'(stable), 1);
    check("stall_overrun", 32'(overrun), 1);
    check("stall_fb_dout", 32'(fb_dout), 32'h1B);
    fb_ack = 1'b1;
    tick();
    check("stall_second_adr", 32'(fb_adr), 1);
    check("stall_second_write", 32'(fb_write), 1);
    tick();
    check("stall_drained", 32'(fb_write), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("stall_overrun_clr", 32'(overrun), 0);

    // Short line 5 raises line_err; next line starts at address 240.
    fresh();
    start_frame();
    fb_ack = 1'b1;
    for (int i = 0; i < 5; i++) line_start();
    check("empty_lines_no_err", 32'(line_err), 0);
    wr_q.delete();
    for (int i = 0; i < 100; i++) send_px(2'd0);
    tick();
    check("line5_bytes", 32'(wr_q.size()), 25);
    check("line5_first_adr", 32'(wr_q[0][20:8]), 200);
    check("line5_last_adr", 32'(wr_q[24][20:8]), 224);
    line_start();
    check("short_line_err", 32'(line_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("line_err_clr", 32'(line_err), 0);
    send_px(2'd3);
    send_px(2'd0);
    send_px(2'd1);
    send_px(2'd2);
    check("line6_write", 32'(fb_write), 1);
    check("line6_adr", 32'(fb_adr), 240);
    hsync   = 1'b1;
    err_clr = 1'b1;
    tick();
    hsync   = 1'b0;
    err_clr = 1'b0;
    check("set_beats_clr", 32'(line_err), 1);

    // disp_on low with two bytes queued.
    fresh();
    start_frame();
    fb_ack = 1'b0;
    for (int i = 0; i < 8; i++) send_px(2'd2);
    check("off_pre_write", 32'(fb_write), 1);
    disp_on = 1'b0;
    tick();
    check("off_write_drop", 32'(fb_write), 0);
    wr_q.delete();
    fb_ack  = 1'b1;
    disp_on = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send_px(2'd1);
    check("off_no_write_pre_vsync", 32'(fb_write), 0);
    check("off_no_acked_writes", 32'(wr_q.size()), 0);
    hsync = 1'b1;
    vsync = 1'b1;
    tick();
    hsync = 1'b0;
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) send_px(2'd3);
    check("off_resume_adr", 32'(fb_adr), 0);
    check("off_resume_dout", 32'(fb_dout), 32'hFF);

    // Reset asserted during a pending write.
    fresh();
    start_frame();
    fb_ack = 1'b0;
    send_px(2'd1);
    send_px(2'd1);
    send_px(2'd1);
    send_px(2'd1);
    check("mid_rst_pre_write", 32'(fb_write), 1);
    wr_q.delete();
    fb_ack = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_fb_write", 32'(fb_write), 0);
    check("mid_rst_fb_adr", 32'(fb_adr), 0);
    check("mid_rst_fb_dout", 32'(fb_dout), 0);
    check("mid_rst_frame_done", 32'(frame_done), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send_px(2'd2);
    check("mid_rst_no_writes", 32'(wr_q.size()), 0);
    check("mid_rst_no_frame_done", 32'(fd_cnt), 0);
    hsync = 1'b1;
    vsync = 1'b1;
    tick();
    hsync = 1'b0;
    vsync = 1'b0;
    send_px(2'd1);
    send_px(2'd2);
    send_px(2'd3);
    send_px(2'd0);
    check("mid_rst_resume_adr", 32'(fb_adr), 0);
    check("mid_rst_resume_dout", 32'(fb_dout), 32'h6C);

    // Full frame with ack tied high; pixel (x,y) = (x+y)%4.
    reset_n = 1'b0;
    fresh();
    reset_n = 1'b1;
    tick();
    wr_q.delete();
    fd_cnt = 0;
    fb_ack = 1'b1;
    start_frame();
    for (int y = 0; y < H; y++) begin
      if (y > 0) line_start();
      for (int x = 0; x < W; x++) send_px(2'((x + y) % 4));
    end
    tick();
    tick();
    tick();
    adr_bad = 0;
    dat_bad = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      yy = i / BPL;
      xx = (i % BPL) * 4;
      e  = {2'((xx + yy) % 4), 2'((xx + 1 + yy) % 4), 2'((xx + 2 + yy) % 4), 2'((xx + 3 + yy) % 4)};
      if (wr_q[i][20:8] != 13'(i)) adr_bad++;
      if (wr_q[i][7:0] != e) dat_bad++;
    end
    check("frame_writes", 32'(wr_q.size()), NBYTES);
    check("frame_adr_order", 32'(adr_bad), 0);
    check("frame_data", 32'(dat_bad), 0);
    check("frame_done_count", 32'(fd_cnt), 1);
    check("frame_done_adr", 32'(fd_adr), NBYTES - 1);
    check("frame_line_err", 32'(line_err), 0);
    check("frame_overrun", 32'(overrun), 0);

    // Pixel below the last visible line is refused and flagged.
    line_start();
    check("end_hsync_no_err", 32'(line_err), 0);
    send_px(2'd3);
    tick();
    check("below_frame_err", 32'(line_err), 1);
    check("below_frame_no_write", 32'(wr_q.size()), NBYTES);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lr35902_lcd.md
LR35902_LCD -- requirements
Module: lr35902_lcd

Interface
REQ-001 SHALL have parameter WIDTH, default 160, meaning visible pixels per line (multiple of 4).
REQ-002 SHALL have parameter HEIGHT, default 144, meaning visible lines per frame.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port disp_on  in  1  display enabled by the PPU.
REQ-006 SHALL have port hsync  in  1  line start strobe, one clk wide.
REQ-007 SHALL have port vsync  in  1  frame start strobe, one clk wide, coincident with hsync.
REQ-008 SHALL have port px_out  in  1  px is valid this clk.
REQ-009 SHALL have port px  in  2  pixel shade.
REQ-010 SHALL have port fb_adr  out  13  framebuffer byte address.
REQ-011 SHALL have port fb_dout  out  8  packed byte: 4 pixels, first pixel in bits 7:6.
REQ-012 SHALL have port fb_write  out  1  write request.
REQ-013 SHALL have port fb_ack  in  1  write accepted this clk.
REQ-014 SHALL have port frame_done  out  1  one-clk pulse, last frame byte accepted.
REQ-015 SHALL have port line_err  out  1  sticky protocol error.
REQ-016 SHALL have port overrun  out  1  sticky dropped-byte flag.
REQ-017 SHALL have port err_clr  in  1  clears line_err and overrun.

Function
REQ-018 SHALL implement states OFF, WAIT_FRAME, CAPTURE; disp_on low forces OFF in the next clk from any state.
REQ-019 SHALL go OFF->WAIT_FRAME when disp_on is high, and WAIT_FRAME->CAPTURE on vsync (with y=0, x=0).
REQ-020 SHALL, in CAPTURE, count x 0..WIDTH per accepted pixel; hsync sets x=0 and increments y, saturating at 255; vsync sets y=0.
REQ-021 SHALL, on hsync with x not in {0, WIDTH} and y<HEIGHT, set line_err.
REQ-022 SHALL ignore px_out with x==WIDTH or y>=HEIGHT and set line_err; px_out in OFF/WAIT_FRAME is ignored silently.
REQ-023 SHALL, when hsync and px_out coincide, apply hsync first and treat the pixel as x=0 of the new line.
REQ-024 SHALL shift pixels into an 8-bit packer MSB-first; on the 4th pixel the byte is pushed with address y*(WIDTH/4)+x/4 (x of first pixel), range 0..5759 at defaults.
REQ-025 SHALL buffer pushed bytes in a 2-entry FIFO with 1-clk push-to-fb_write latency.
REQ-026 SHALL hold fb_write, fb_adr and fb_dout stable while FIFO is non-empty until fb_ack is sampled high; the head pops on that clk.
REQ-027 SHALL accept a push into a full FIFO if fb_ack pops the head in the same clk; otherwise SHALL drop the byte and set overrun.
REQ-028 SHALL pulse frame_done on the clk the byte with address HEIGHT*WIDTH/4-1 is acked.
REQ-029 SHALL give set priority over err_clr when both occur in the same clk.
REQ-030 SHALL, on entry to OFF, discard FIFO contents and packer; fb_write drops in that clk's next state.
REQ-031 SHALL treat fb_ack while fb_write is low as no-op.

Reset
REQ-032 SHALL, while reset_n is low, hold state=OFF, x=0, y=0, FIFO empty, fb_write=0, fb_adr=0, fb_dout=0, frame_done=0, line_err=0, overrun=0.
REQ-033 SHALL, on reset mid-write, abandon the transfer without completing it; first write after release follows a new vsync.

Structure
REQ-034 SHALL place state encodings and the WIDTH/HEIGHT defaults in the shared PPU constants package.
REQ-035 SHALL implement the 2-entry FIFO as sub-module lr35902_lcd_fifo (13+8 bit entries, push/pop/full/empty).

Verification
REQ-036 SHALL check: full frame, fb_ack tied high -> 5760 writes, addresses 0..5759 in order, one frame_done, no errors.
REQ-037 SHALL check: pixels 3,0,1,2 at line 0 start -> fb_adr=0, fb_dout=0xC6.
REQ-038 SHALL check: fb_ack low for 12 clks during line 0 -> overrun=1, fb_write held with fb_adr=0 stable throughout.
REQ-039 SHALL check: hsync after 100 pixels on line 5 -> line_err=1; err_clr -> 0; next line address starts at 240.
REQ-040 SHALL check: disp_on low mid-line with 2 bytes queued -> fb_write=0 next clk, no further writes until after next vsync.
REQ-041 SHALL check: reset_n low during fb_write -> all outputs 0 immediately, no frame_done.
